fwd_scoreboard: RTL and testbench
=================================

FWD_SCOREBOARD -- requirements
Module: fwd_scoreboard

Interface
REQ-001 Parameter XLEN, default 32, datapath width.
REQ-002 Parameter NREG, default 16, architectural register count; RW = clog2(NREG).
REQ-003 Parameter NSRC, default 2, source operands per instruction.
REQ-004 Parameter DEPTH, default 3, tracked stages after decode (index 0 = EX, DEPTH-1 = WB).
REQ-005 Parameter LOAD_LAT, default 1, first stage index holding valid load data.
REQ-006 Parameter FLUSH_N, default 1, youngest tracked stages killed by flush.
REQ-007 Port clk_i  in  1  the single clock; all state changes on its rising edge.
REQ-008 Port rst_ni  in  1  asynchronous, active-low reset.
REQ-009 Port id_valid_i  in  1  valid instruction in decode.
REQ-010 Port id_src_i  in  NSRC*RW  source register indices.
REQ-011 Port id_src_used_i  in  NSRC  per-source "operand read" flag.
REQ-012 Port id_dst_i  in  RW  destination register.
REQ-013 Port id_wen_i  in  1  instruction writes id_dst_i.
REQ-014 Port id_is_load_i  in  1  instruction is a load.
REQ-015 Port flush_i  in  1  taken branch resolved; kill wrong-path instructions.
REQ-016 Port mem_busy_i  in  1  memory not ready; freeze pipeline.
REQ-017 Port stage_data_i  in  DEPTH*XLEN  result bus of each tracked stage.
REQ-018 Port stall_o  out  1  hold PC and IF/ID, insert bubble into EX.
REQ-019 Port fwd_sel_o  out  NSRC*clog2(DEPTH+1)  0 = register file, k = stage k-1.
REQ-020 Port fwd_data_o  out  NSRC*XLEN  selected bypass data (zero when sel = 0).
REQ-021 Port stall_cnt_o  out  16  saturating count of stall cycles.

Function
REQ-022 Tracker holds DEPTH entries {valid, dst, is_load}; register 0 is never tracked (hardwired zero).
REQ-023 Entry k result is ready iff valid and (not is_load or k >= LOAD_LAT).
REQ-024 Match for source s: id_src_used_i[s], id_src_i[s] != 0, entry valid, entry dst == id_src_i[s].
REQ-025 Forwarding selects the lowest-index (youngest) matching entry; fwd_sel_o/fwd_data_o are combinational, zero latency.
REQ-026 stall_o = mem_busy_i, or id_valid_i with youngest match for any source not ready (load-use).
REQ-027 Issue = id_valid_i and not stall_o and not flush_i.
REQ-028 Advance cycle (mem_busy_i = 0): entries shift k -> k+1, entry DEPTH-1 retires; entry 0 loads {1, id_dst_i, id_is_load_i} if issue and id_wen_i and id_dst_i != 0, otherwise an invalid bubble.
REQ-029 Freeze cycle (mem_busy_i = 1): no shift, no insertion.
REQ-030 flush_i clears valid of entries 0..FLUSH_N-1 before the shift, in both advance and freeze cycles; decode instruction is not inserted.
REQ-031 flush_i and load-use stall in the same cycle: flush wins, bubble inserted, entries cleared.
REQ-032 stall_cnt_o increments on every cycle with stall_o = 1, saturates at 0xFFFF, never wraps.
REQ-033 Multiple matching entries with different readiness: only the youngest decides stall and forward.

Reset
REQ-034 rst_ni low clears all entry valid bits and stall_cnt_o immediately, independent of clk_i.
REQ-035 During and after reset with no valid decode: stall_o = 0, fwd_sel_o = 0, fwd_data_o = 0.
REQ-036 Reset asserted mid-stall drops stall_o in the same cycle unless mem_busy_i is high.

Structure
REQ-037 Entry struct type, fwd-select width function and default parameter constants live in the shared CPU package.
REQ-038 One sub-module fwd_match (per-source priority match and mux), instantiated NSRC times.

Verification
REQ-039 ALU r3 <- 5 in EX, decode reads r3 -> stall_o = 0, fwd_sel = 1, fwd_data = stage_data[0].
REQ-040 Load r4 in EX (LOAD_LAT = 1), decode reads r4 -> stall_o = 1 one cycle, then fwd_sel = 2, stall_cnt_o = 1.
REQ-041 Writes to r2 in EX and WB, decode reads r2 -> fwd_sel = 1 (youngest).
REQ-042 Load-use stall with flush_i the same cycle -> entry 0 cleared, next cycle stall_o = 0, nothing issued.
REQ-043 mem_busy_i high 3 cycles -> tracker frozen, stall_o = 1 three cycles, stall_cnt_o += 3; write to r0 never forwards.
REQ-044 rst_ni pulled low mid-stall -> entries invalid, stall_cnt_o = 0, outputs zero asynchronously.

Source files
------------

// File: rtl/fwd_scoreboard_pkg.sv
// Shared CPU package for the forwarding scoreboard: tracker entry type,
// forward-select width helper and default parameter values.
package fwd_scoreboard_pkg;

    localparam int unsigned DefXlen    = 32;
    localparam int unsigned DefNreg    = 16;
    localparam int unsigned DefNsrc    = 2;
    localparam int unsigned DefDepth   = 3;
    localparam int unsigned DefLoadLat = 1;
    localparam int unsigned DefFlushN  = 1;

    // Entry dst is stored zero-extended to this width so the struct type is
    // independent of NREG (supports up to 256 architectural registers).
    localparam int unsigned MaxRw = 8;

    typedef struct packed {
        logic             valid;
        logic             is_load;
        logic [MaxRw-1:0] dst;
    } fwd_entry_t;

    // Select code 0 means register file, k means tracked stage k-1.
    function automatic int unsigned fwd_sel_width(int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fwd_match.sv
// Per-source priority match against the tracker: picks the youngest matching
// entry, muxes its stage result and flags a hazard when that entry is not ready.
module fwd_match
    import fwd_scoreboard_pkg::*;
#(
    parameter int unsigned XLEN     = DefXlen,
    parameter int unsigned DEPTH    = DefDepth,
    parameter int unsigned LOAD_LAT = DefLoadLat,
    parameter int unsigned SW       = fwd_sel_width(DefDepth)
) (
    input  logic [MaxRw-1:0]     i_src,
    input  logic                 i_used,
    input  fwd_entry_t [DEPTH-1:0] i_entries,
    input  logic [DEPTH*XLEN-1:0] i_stage_data,
    output logic [SW-1:0]        o_sel,
    output logic [XLEN-1:0]      o_data,
    output logic                 o_hazard
);

    // Walk oldest to youngest so the youngest match overwrites older ones.
    always_comb begin
        o_sel    = '0;
        o_data   = '0;
        o_hazard = 1'b0;
        if (i_used && (i_src != '0)) begin
            for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
                if (i_entries[k].valid && (i_entries[k].dst == i_src)) begin
                    o_sel    = SW'(k + 1);
                    o_data   = i_stage_data[k*XLEN +: XLEN];
                    o_hazard = i_entries[k].is_load && (k < int'(LOAD_LAT));
                end
            end
        end
    end

endmodule

// File: rtl/fwd_scoreboard.sv
// Forwarding scoreboard: tracks in-flight destination registers after decode,
// drives bypass selects/data and the load-use / memory-busy stall.
module fwd_scoreboard
    import fwd_scoreboard_pkg::*;
#(
    parameter int unsigned XLEN     = DefXlen,
    parameter int unsigned NREG     = DefNreg,
    parameter int unsigned NSRC     = DefNsrc,
    parameter int unsigned DEPTH    = DefDepth,
    parameter int unsigned LOAD_LAT = DefLoadLat,
    parameter int unsigned FLUSH_N  = DefFlushN,
    localparam int unsigned RW      = $clog2(NREG),
    localparam int unsigned SW      = fwd_sel_width(DEPTH)
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   id_valid_i,
    input  logic [NSRC*RW-1:0]     id_src_i,
    input  logic [NSRC-1:0]        id_src_used_i,
    input  logic [RW-1:0]          id_dst_i,
    input  logic                   id_wen_i,
    input  logic                   id_is_load_i,
    input  logic                   flush_i,
    input  logic                   mem_busy_i,
    input  logic [DEPTH*XLEN-1:0]  stage_data_i,
    output logic                   stall_o,
    output logic [NSRC*SW-1:0]     fwd_sel_o,
    output logic [NSRC*XLEN-1:0]   fwd_data_o,
    output logic [15:0]            stall_cnt_o
);

    fwd_entry_t [DEPTH-1:0] r_entries;
    fwd_entry_t [DEPTH-1:0] w_entries_flushed;
    fwd_entry_t [DEPTH-1:0] w_entries_next;
    fwd_entry_t             w_insert;
    logic [MaxRw-1:0]       w_dst_ext;
    logic [NSRC-1:0]        w_hazard;
    logic                   w_stall;
    logic                   w_issue;
    logic [15:0]            r_stall_cnt;

    for (genvar s = 0; s < NSRC; s++) begin : g_src
        logic [MaxRw-1:0] w_src_ext;

        // Zero-extend the source index to the entry dst width.
        always_comb begin
            w_src_ext         = '0;
            w_src_ext[RW-1:0] = id_src_i[s*RW +: RW];
        end

        fwd_match #(
            .XLEN     (XLEN),
            .DEPTH    (DEPTH),
            .LOAD_LAT (LOAD_LAT),
            .SW       (SW)
        ) u_match (
            .i_src        (w_src_ext),
            .i_used       (id_src_used_i[s]),
            .i_entries    (r_entries),
            .i_stage_data (stage_data_i),
            .o_sel        (fwd_sel_o[s*SW +: SW]),
            .o_data       (fwd_data_o[s*XLEN +: XLEN]),
            .o_hazard     (w_hazard[s])
        );
    end

    assign w_stall     = mem_busy_i | (id_valid_i & (|w_hazard));
    assign w_issue     = id_valid_i & ~w_stall & ~flush_i;
    assign stall_o     = w_stall;
    assign stall_cnt_o = r_stall_cnt;

    // Build the entry inserted at EX: only issued writes to non-zero registers.
    always_comb begin
        w_dst_ext         = '0;
        w_dst_ext[RW-1:0] = id_dst_i;
        w_insert          = '0;
        if (w_issue && id_wen_i && (id_dst_i != '0)) begin
            w_insert.valid   = 1'b1;
            w_insert.is_load = id_is_load_i;
            w_insert.dst     = w_dst_ext;
        end
    end

    // Next tracker state: flush kills the youngest entries, then shift unless frozen.
    always_comb begin
        w_entries_flushed = r_entries;
        if (flush_i) begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                if (k < FLUSH_N) begin
                    w_entries_flushed[k].valid = 1'b0;
                end
            end
        end
        if (mem_busy_i) begin
            w_entries_next = w_entries_flushed;
        end else begin
            w_entries_next[0] = w_insert;
            for (int unsigned k = 1; k < DEPTH; k++) begin
                w_entries_next[k] = w_entries_flushed[k-1];
            end
        end
    end

    // Tracker register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_entries <= '0;
        end else begin
            r_entries <= w_entries_next;
        end
    end

    // Saturating stall-cycle counter.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Self-checking bench for fwd_scoreboard: directed scenarios with literal
// expectations, then randomized traffic against a queue-based pipeline model.
module tb_fwd_scoreboard;

    localparam int XLEN     = 32;
    localparam int NREG     = 16;
    localparam int NSRC     = 2;
    localparam int DEPTH    = 3;
    localparam int LOAD_LAT = 1;
    localparam int FLUSH_N  = 1;
    localparam int RW       = 4;
    localparam int SW       = 2;

    logic                  clk;
    logic                  rst_n;
    logic                  id_valid;
    logic [NSRC*RW-1:0]    id_src;
    logic [NSRC-1:0]       id_used;
    logic [RW-1:0]         id_dst;
    logic                  id_wen;
    logic                  id_is_load;
    logic                  flush;
    logic                  mem_busy;
    logic [DEPTH*XLEN-1:0] stage_data;
    logic                  stall_o;
    logic [NSRC*SW-1:0]    fwd_sel_o;
    logic [NSRC*XLEN-1:0]  fwd_data_o;
    logic [15:0]           stall_cnt_o;

    int n_cmp  = 0;
    int n_fail = 0;

    fwd_scoreboard #(
        .XLEN     (XLEN),
        .NREG     (NREG),
        .NSRC     (NSRC),
        .DEPTH    (DEPTH),
        .LOAD_LAT (LOAD_LAT),
        .FLUSH_N  (FLUSH_N)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .id_valid_i    (id_valid),
        .id_src_i      (id_src),
        .id_src_used_i (id_used),
        .id_dst_i      (id_dst),
        .id_wen_i      (id_wen),
        .id_is_load_i  (id_is_load),
        .flush_i       (flush),
        .mem_busy_i    (mem_busy),
        .stage_data_i  (stage_data),
        .stall_o       (stall_o),
        .fwd_sel_o     (fwd_sel_o),
        .fwd_data_o    (fwd_data_o),
        .stall_cnt_o   (stall_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: list of in-flight writers, index 0 = EX (youngest).
    typedef struct packed {
        logic          v;
        logic          ld;
        logic [RW-1:0] dst;
    } ment_t;
    typedef ment_t mpipe_t [DEPTH];

    mpipe_t      m_pipe;
    logic [15:0] m_cnt;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int youngest(input mpipe_t p, input logic [RW-1:0] src, input logic used);
        if (!used || src == '0) return -1;
        for (int k = 0; k < DEPTH; k++) begin
            if (p[k].v && p[k].dst == src) return k;
        end
        return -1;
    endfunction

    function automatic logic exp_stall(input mpipe_t p, input logic busy, input logic valid,
                                       input logic [NSRC*RW-1:0] srcs,
                                       input logic [NSRC-1:0] used);
        logic hz;
        int   k;
        hz = 1'b0;
        for (int s = 0; s < NSRC; s++) begin
            k = youngest(p, srcs[s*RW +: RW], used[s]);
            if (k >= 0 && p[k].ld && k < LOAD_LAT) hz = 1'b1;
        end
        return busy || (valid && hz);
    endfunction

    function automatic logic [NSRC*SW-1:0] exp_sel(input mpipe_t p,
                                                   input logic [NSRC*RW-1:0] srcs,
                                                   input logic [NSRC-1:0] used);
        logic [NSRC*SW-1:0] r;
        int                 k;
        r = '0;
        for (int s = 0; s < NSRC; s++) begin
            k = youngest(p, srcs[s*RW +: RW], used[s]);
            if (k >= 0) r[s*SW +: SW] = SW'(k + 1);
        end
        return r;
    endfunction

    function automatic logic [NSRC*XLEN-1:0] exp_data(input mpipe_t p,
                                                      input logic [NSRC*RW-1:0] srcs,
                                                      input logic [NSRC-1:0] used,
                                                      input logic [DEPTH*XLEN-1:0] sd);
        logic [NSRC*XLEN-1:0] r;
        int                   k;
        r = '0;
        for (int s = 0; s < NSRC; s++) begin
            k = youngest(p, srcs[s*RW +: RW], used[s]);
            if (k >= 0) r[s*XLEN +: XLEN] = sd[k*XLEN +: XLEN];
        end
        return r;
    endfunction

    function automatic mpipe_t model_next(input mpipe_t p, input logic busy, input logic fl,
                                          input logic wr, input logic [RW-1:0] dst,
                                          input logic ld);
        ment_t  q[$];
        ment_t  ins;
        mpipe_t r;
        for (int i = 0; i < DEPTH; i++) q.push_back(p[i]);
        if (fl) begin
            for (int i = 0; i < FLUSH_N; i++) q[i].v = 1'b0;
        end
        if (!busy) begin
            ins = '0;
            if (wr) begin
                ins.v   = 1'b1;
                ins.ld  = ld;
                ins.dst = dst;
            end
            q.push_front(ins);
            void'(q.pop_back());
        end
        for (int i = 0; i < DEPTH; i++) r[i] = q[i];
        return r;
    endfunction

    // Model state advances on the same edge as the DUT, reset asynchronously.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pipe <= '{default: '0};
            m_cnt  <= 16'd0;
        end else begin
            m_pipe <= model_next(m_pipe, mem_busy, flush,
                                 id_valid && !flush && id_wen && (id_dst != '0) &&
                                 !exp_stall(m_pipe, mem_busy, id_valid, id_src, id_used),
                                 id_dst, id_is_load);
            if (exp_stall(m_pipe, mem_busy, id_valid, id_src, id_used) && m_cnt != 16'hFFFF)
                m_cnt <= m_cnt + 16'd1;
        end
    end

    // Compare process: outputs checked against the model every cycle.
    always @(negedge clk) begin
        chk("cyc_stall", stall_o, exp_stall(m_pipe, mem_busy, id_valid, id_src, id_used));
        chk("cyc_sel", fwd_sel_o, exp_sel(m_pipe, id_src, id_used));
        chk("cyc_data", fwd_data_o, exp_data(m_pipe, id_src, id_used, stage_data));
        chk("cyc_cnt", stall_cnt_o, m_cnt);
    end

    task automatic drive(input logic v, input logic [RW-1:0] s0, input logic [RW-1:0] s1,
                         input logic [1:0] used, input logic [RW-1:0] dst, input logic wen,
                         input logic ld, input logic fl, input logic busy);
        id_valid   = v;
        id_src     = {s1, s0};
        id_used    = used;
        id_dst     = dst;
        id_wen     = wen;
        id_is_load = ld;
        flush      = fl;
        mem_busy   = busy;
        stage_data = {$urandom(), $urandom(), $urandom()};
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b1;
        drive(0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_stall", stall_o, 0);
        chk("rst_sel", fwd_sel_o, 0);
        chk("rst_data", fwd_data_o, 0);
        chk("rst_cnt", stall_cnt_o, 0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // ALU r3 in EX, decode reads r3.
        drive(1, 0, 0, 2'b00, 3, 1, 0, 0, 0); tick();
        drive(1, 3, 0, 2'b01, 0, 0, 0, 0, 0); #1;
        chk("alu_stall", stall_o, 0);
        chk("alu_sel", fwd_sel_o[SW-1:0], 1);
        chk("alu_data", fwd_data_o[XLEN-1:0], stage_data[XLEN-1:0]);
        tick();

        // r2 written in EX and WB: youngest wins.
        drive(1, 0, 0, 2'b00, 2, 1, 0, 0, 0); tick();
        drive(1, 0, 0, 2'b00, 0, 0, 0, 0, 0); tick();
        drive(1, 0, 0, 2'b00, 2, 1, 0, 0, 0); tick();
        drive(1, 0, 2, 2'b10, 0, 0, 0, 0, 0); #1;
        chk("two_wr_sel", fwd_sel_o, {2'd1, 2'd0});
        chk("two_wr_data", fwd_data_o[2*XLEN-1:XLEN], stage_data[XLEN-1:0]);
        tick();

        // Load-use on r4: one stall cycle then forward from stage 1.
        drive(1, 0, 0, 2'b00, 4, 1, 1, 0, 0); tick();
        drive(1, 4, 0, 2'b01, 0, 0, 0, 0, 0); #1;
        chk("lu_stall", stall_o, 1);
        chk("lu_sel_stall", fwd_sel_o[SW-1:0], 1);
        tick();
        drive(1, 4, 0, 2'b01, 0, 0, 0, 0, 0); #1;
        chk("lu_stall_after", stall_o, 0);
        chk("lu_sel", fwd_sel_o[SW-1:0], 2);
        chk("lu_data", fwd_data_o[XLEN-1:0], stage_data[2*XLEN-1:XLEN]);
        chk("lu_cnt", stall_cnt_o, 1);
        tick();

        // Load-use with flush in the same cycle: load killed.
        drive(1, 0, 0, 2'b00, 5, 1, 1, 0, 0); tick();
        drive(1, 5, 0, 2'b01, 0, 0, 0, 1, 0); #1;
        chk("fl_stall", stall_o, 1);
        tick();
        drive(1, 5, 0, 2'b01, 0, 0, 0, 0, 0); #1;
        chk("fl_stall_after", stall_o, 0);
        chk("fl_sel", fwd_sel_o, 0);
        chk("fl_cnt", stall_cnt_o, 2);
        tick();

        // Memory busy freezes tracker; r0 write never tracked.
        drive(1, 0, 0, 2'b00, 6, 1, 0, 0, 0); tick();
        drive(1, 0, 0, 2'b00, 0, 1, 0, 0, 0); tick();
        repeat (3) begin
            drive(1, 0, 6, 2'b11, 0, 0, 0, 0, 1); #1;
            chk("busy_stall", stall_o, 1);
            chk("busy_sel", fwd_sel_o, {2'd2, 2'd0});
            tick();
        end
        drive(1, 0, 6, 2'b11, 0, 0, 0, 0, 0); #1;
        chk("busy_end_stall", stall_o, 0);
        chk("busy_end_sel", fwd_sel_o, {2'd2, 2'd0});
        chk("busy_cnt", stall_cnt_o, 5);
        tick();

        // Reset pulled mid-stall.
        drive(1, 0, 0, 2'b00, 7, 1, 1, 0, 0); tick();
        drive(1, 7, 0, 2'b01, 0, 0, 0, 0, 0); #1;
        chk("mid_stall", stall_o, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_stall", stall_o, 0);
        chk("mid_rst_sel", fwd_sel_o, 0);
        chk("mid_rst_data", fwd_data_o, 0);
        chk("mid_rst_cnt", stall_cnt_o, 0);
        tick();
        tick();
        rst_n = 1'b1;

        // Randomized traffic over a small register window to force overlaps.
        repeat (3000) begin
            drive(($urandom_range(0, 3) != 0),
                  RW'($urandom_range(0, 5)), RW'($urandom_range(0, 5)),
                  2'($urandom_range(0, 3)), RW'($urandom_range(0, 5)),
                  ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 9) == 0), ($urandom_range(0, 7) == 0));
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
